// File: rtl/imem_fetch_ctrl.sv
// Instruction fetch sequencer: owns the PC, paces memory reads and buffers words for decode.
// Optional IMEM_FETCH_ALIGN_CHECK_EN: misaligned redirects vector to EXC_VECTOR and pulse AlignFault.
module imem_fetch_ctrl #(
    parameter logic [31:0] RESET_PC    = 32'h0000_0000,
    parameter logic [31:0] EXC_VECTOR  = 32'hF000_0000,
    parameter int unsigned WAIT_STATES = 2
) (
    input  logic        CLK,
    input  logic        Reset_L,
    output logic [31:0] ImemAddr,
    input  logic [31:0] ImemData,
    input  logic        Redirect,
    input  logic [31:0] RedirectPC,
    input  logic        Exception,
    input  logic        Halt,
    output logic        InstrValid,
    output logic [31:0] Instr,
    output logic [31:0] InstrPC,
    input  logic        InstrReady,
    output logic        AlignFault
);
    typedef enum logic [1:0] {StIdle, StWait, StCapt} state_e;

    localparam state_e     IssueState = (WAIT_STATES == 0) ? StCapt : StWait;
    localparam logic [3:0] WaitInit   = (WAIT_STATES == 0) ? 4'd0 : 4'(WAIT_STATES - 1);

    state_e           state_q;
    logic [3:0]       wait_cnt_q;
    logic [31:0]      pc_q;
    logic [1:0]       q_count_q;
    logic [1:0][31:0] q_data_q;
    logic [1:0][31:0] q_pc_q;
    logic             align_fault_q;

    logic             pop;
    logic             push;
    logic             flush;
    logic             take_exc;
    logic             misaligned;
    logic             write_slot0;
    logic [2:0]       count_after;
    logic [31:0]      redir_pc;

`ifdef IMEM_FETCH_ALIGN_CHECK_EN
    assign misaligned = Redirect && (RedirectPC[1:0] != 2'b00);
    assign redir_pc   = RedirectPC;
`else
    logic unused_redirect_lsbs;
    assign unused_redirect_lsbs = ^RedirectPC[1:0];
    assign misaligned           = 1'b0;
    assign redir_pc             = {RedirectPC[31:2], 2'b00};
`endif

    assign take_exc = Exception || misaligned;
    assign flush    = take_exc || Redirect;

    always_comb begin
        pop         = (q_count_q != 2'd0) && InstrReady;
        push        = (state_q == StCapt);
        count_after = {1'b0, q_count_q} + {2'b00, push} - {2'b00, pop};
        // Head slot shifts out on pop, so the push lands in the first slot left free.
        write_slot0 = (q_count_q == 2'd0) || ((q_count_q == 2'd1) && pop);
    end

    always_ff @(posedge CLK or negedge Reset_L) begin
        if (!Reset_L) begin
            state_q       <= StIdle;
            wait_cnt_q    <= 4'd0;
            pc_q          <= RESET_PC;
            q_count_q     <= 2'd0;
            q_data_q      <= '0;
            q_pc_q        <= '0;
            align_fault_q <= 1'b0;
        end else begin
            align_fault_q <= misaligned;
            if (flush) begin
                // Any in-flight fetch is abandoned; a CAPT in this cycle is not pushed.
                state_q    <= StIdle;
                wait_cnt_q <= 4'd0;
                q_count_q  <= 2'd0;
                pc_q       <= take_exc ? EXC_VECTOR : redir_pc;
            end else begin
                if (pop) begin
                    q_data_q[0] <= q_data_q[1];
                    q_pc_q[0]   <= q_pc_q[1];
                end
                if (push) begin
                    if (write_slot0) begin
                        q_data_q[0] <= ImemData;
                        q_pc_q[0]   <= pc_q;
                    end else begin
                        q_data_q[1] <= ImemData;
                        q_pc_q[1]   <= pc_q;
                    end
                end
                q_count_q <= count_after[1:0];

                unique case (state_q)
                    StIdle: begin
                        if (!Halt && (q_count_q != 2'd2)) begin
                            state_q    <= IssueState;
                            wait_cnt_q <= WaitInit;
                        end
                    end
                    StWait: begin
                        if (wait_cnt_q == 4'd0) begin
                            state_q <= StCapt;
                        end else begin
                            wait_cnt_q <= wait_cnt_q - 4'd1;
                        end
                    end
                    StCapt: begin
                        pc_q <= pc_q + 32'd4;
                        if (!Halt && (count_after < 3'd2)) begin
                            state_q    <= IssueState;
                            wait_cnt_q <= WaitInit;
                        end else begin
                            state_q <= StIdle;
                        end
                    end
                    default: state_q <= StIdle;
                endcase
            end
        end
    end

    assign ImemAddr   = pc_q;
    assign InstrValid = (q_count_q != 2'd0);
    assign Instr      = q_data_q[0];
    assign InstrPC    = q_pc_q[0];
    assign AlignFault = align_fault_q;

endmodule

// File: tb/tb_imem_fetch_ctrl.sv
// Bench for imem_fetch_ctrl: directed scenarios plus randomized traffic checked against a
// stream-level model (expected next PC, memory contents as a function of address).
module tb_imem_fetch_ctrl;
    localparam logic [31:0] RESET_PC = 32'h0000_0000;
    localparam logic [31:0] EXC_VEC  = 32'hF000_0000;

    logic        CLK = 1'b0;
    logic        Reset_L;
    logic [31:0] ImemAddr;
    logic [31:0] ImemData;
    logic        Redirect;
    logic [31:0] RedirectPC;
    logic        Exception;
    logic        Halt;
    logic        InstrValid;
    logic [31:0] Instr;
    logic [31:0] InstrPC;
    logic        InstrReady;
    logic        AlignFault;

    int          n_vec = 0;
    int          n_err = 0;
    int          n_deliv = 0;
    int          cyc = 0;
    int          hs_cyc = 0;
    logic        hs = 1'b0;
    logic [31:0] hs_pc = '0;
    logic [31:0] hs_instr = '0;
    logic [31:0] exp_pc;
    logic        af_pend;

    imem_fetch_ctrl #(
        .RESET_PC   (RESET_PC),
        .EXC_VECTOR (EXC_VEC),
        .WAIT_STATES(2)
    ) dut (
        .CLK       (CLK),
        .Reset_L   (Reset_L),
        .ImemAddr  (ImemAddr),
        .ImemData  (ImemData),
        .Redirect  (Redirect),
        .RedirectPC(RedirectPC),
        .Exception (Exception),
        .Halt      (Halt),
        .InstrValid(InstrValid),
        .Instr     (Instr),
        .InstrPC   (InstrPC),
        .InstrReady(InstrReady),
        .AlignFault(AlignFault)
    );

    always #5 CLK = ~CLK;

    function automatic logic [31:0] mem_word(input logic [31:0] addr);
        case (addr)
            32'h0000_0000: return 32'h3408_0032;
            32'h0000_0004: return 32'hac08_0000;
            32'h0000_0190: return 32'hac09_0054;
            32'hF000_0000: return 32'h8c08_0000;
            default:       return (addr * 32'h9E37_79B1) ^ 32'h5A5A_1234;
        endcase
    endfunction

    assign ImemData = mem_word(ImemAddr);

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
        end
    endtask

    // One clock: sample at negedge, score the handshake, update the model, step past posedge.
    task automatic tick();
        @(negedge CLK);
        hs = 1'b0;
        check_eq("align_fault", {31'b0, AlignFault}, {31'b0, Reset_L ? af_pend : 1'b0});
        if (Reset_L && InstrValid && InstrReady) begin
            check_eq("instr_pc", InstrPC, exp_pc);
            check_eq("instr", Instr, mem_word(exp_pc));
            hs       = 1'b1;
            hs_cyc   = cyc;
            hs_pc    = InstrPC;
            hs_instr = Instr;
            exp_pc   = exp_pc + 32'd4;
            n_deliv++;
        end
        af_pend = 1'b0;
        if (!Reset_L) begin
            exp_pc = RESET_PC;
        end else begin
`ifdef IMEM_FETCH_ALIGN_CHECK_EN
            af_pend = Redirect && (RedirectPC[1:0] != 2'b00);
            if (Exception || af_pend) exp_pc = EXC_VEC;
            else if (Redirect) exp_pc = RedirectPC;
`else
            if (Exception) exp_pc = EXC_VEC;
            else if (Redirect) exp_pc = {RedirectPC[31:2], 2'b00};
`endif
        end
        @(posedge CLK);
        #1;
        cyc++;
    endtask

    task automatic wait_hs(input string tag);
        for (int i = 0; i < 30; i++) begin
            tick();
            if (hs) break;
        end
        check_eq(tag, {31'b0, hs}, 32'd1);
    endtask

    task automatic do_reset();
        Reset_L = 1'b0;
        tick();
        tick();
        Reset_L = 1'b1;
        cyc     = 0;
    endtask

    initial begin
        int first_cyc;
        int second_cyc;
        int base;

        Reset_L    = 1'b0;
        Redirect   = 1'b0;
        Exception  = 1'b0;
        Halt       = 1'b0;
        InstrReady = 1'b1;
        RedirectPC = '0;
        exp_pc     = RESET_PC;
        af_pend    = 1'b0;

        // Reset state
        tick();
        tick();
        check_eq("rst_addr", ImemAddr, RESET_PC);
        check_eq("rst_valid", {31'b0, InstrValid}, 32'd0);
        check_eq("rst_instr", Instr, 32'd0);
        check_eq("rst_instr_pc", InstrPC, 32'd0);
        check_eq("rst_align", {31'b0, AlignFault}, 32'd0);

        // First delivery latency and steady-state spacing
        Reset_L    = 1'b1;
        cyc        = 0;
        first_cyc  = -1;
        second_cyc = -1;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (hs && first_cyc < 0) first_cyc = hs_cyc;
            else if (hs && second_cyc < 0) second_cyc = hs_cyc;
        end
        check_eq("first_valid_cycle", 32'(first_cyc), 32'd4);
        check_eq("second_valid_cycle", 32'(second_cyc), 32'd7);

        // Back-pressure: queue fills with 0x00/0x04, fetch stalls at 0x08
        InstrReady = 1'b0;
        do_reset();
        for (int i = 0; i < 20; i++) tick();
        check_eq("full_valid", {31'b0, InstrValid}, 32'd1);
        check_eq("full_head_pc", InstrPC, 32'h0);
        check_eq("full_addr", ImemAddr, 32'h8);
        for (int i = 0; i < 5; i++) tick();
        check_eq("full_addr_hold", ImemAddr, 32'h8);
        InstrReady = 1'b1;
        base = n_deliv;
        for (int i = 0; i < 15; i++) tick();
        check_eq("drain_count", {31'b0, (n_deliv - base) >= 3}, 32'd1);

        // Redirect with fetch in flight
        tick();
        Redirect   = 1'b1;
        RedirectPC = 32'h190;
        tick();
        Redirect = 1'b0;
        wait_hs("redirect_timeout");
        check_eq("redirect_pc", hs_pc, 32'h190);
        check_eq("redirect_instr", hs_instr, 32'hac09_0054);

        // Exception beats Redirect
        tick();
        Exception  = 1'b1;
        Redirect   = 1'b1;
        RedirectPC = 32'h180;
        tick();
        Exception = 1'b0;
        Redirect  = 1'b0;
        wait_hs("exception_timeout");
        check_eq("exception_pc", hs_pc, EXC_VEC);
        check_eq("exception_instr", hs_instr, 32'h8c08_0000);

        // Halt: drain, then address parks on the next PC
        Halt = 1'b1;
        for (int i = 0; i < 15; i++) tick();
        check_eq("halt_valid", {31'b0, InstrValid}, 32'd0);
        check_eq("halt_addr", ImemAddr, exp_pc);
        for (int i = 0; i < 4; i++) tick();
        check_eq("halt_addr_hold", ImemAddr, exp_pc);
        Halt = 1'b0;
        wait_hs("resume_timeout");

        // PC wrap past 0xFFFFFFFC
        Redirect   = 1'b1;
        RedirectPC = 32'hFFFF_FFF8;
        tick();
        Redirect = 1'b0;
        wait_hs("wrap_timeout0");
        wait_hs("wrap_timeout1");
        wait_hs("wrap_timeout2");
        check_eq("wrap_pc", hs_pc, 32'h0);

        // Reset mid-WAIT at 0x2C
        do_reset();
        for (int i = 0; i < 60 && ImemAddr !== 32'h2C; i++) tick();
        check_eq("reach_2c", ImemAddr, 32'h2C);
        tick();
        Reset_L = 1'b0;
        #1;
        check_eq("async_rst_valid", {31'b0, InstrValid}, 32'd0);
        check_eq("async_rst_instr", Instr, 32'd0);
        check_eq("async_rst_addr", ImemAddr, RESET_PC);
        tick();
        Reset_L = 1'b1;
        cyc     = 0;
        wait_hs("restart_timeout");
        check_eq("restart_cycle", 32'(hs_cyc), 32'd4);
        check_eq("restart_pc", hs_pc, 32'h0);
        check_eq("restart_instr", hs_instr, 32'h3408_0032);

        // Misaligned redirect
        Redirect   = 1'b1;
        RedirectPC = 32'h192;
        tick();
        Redirect = 1'b0;
        wait_hs("align_timeout");
`ifdef IMEM_FETCH_ALIGN_CHECK_EN
        check_eq("align_pc", hs_pc, EXC_VEC);
`else
        check_eq("align_pc", hs_pc, 32'h190);
`endif

        // Randomized traffic
        base = n_deliv;
        for (int i = 0; i < 3000; i++) begin
            InstrReady = ($urandom % 4) != 0;
            Halt       = ($urandom % 6) == 0;
            Redirect   = ($urandom % 40) == 0;
            Exception  = ($urandom % 60) == 0;
            Reset_L    = ($urandom % 400) != 0;
            if (($urandom % 4) == 0) RedirectPC = 32'hFFFF_FFF0 | ($urandom % 16);
            else RedirectPC = $urandom % 32'h1000;
            tick();
        end
        Reset_L   = 1'b1;
        Redirect  = 1'b0;
        Exception = 1'b0;
        Halt      = 1'b0;
        check_eq("random_throughput", {31'b0, (n_deliv - base) > 200}, 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
